// File: rtl/tile_arb_pkg.sv
// Shared types and default sizes for the tile memory arbiter.
// Optional statistics counter is enabled by defining ARB_STAT_EN (see tile_mem_arbiter).
package tile_arb_pkg;

    localparam int unsigned AW         = 10;
    localparam int unsigned DW         = 8;
    localparam int unsigned ARB_FDEPTH = 4;
    localparam int unsigned STAT_W     = 16;

    typedef logic [AW-1:0] tile_addr_t;
    typedef logic [DW-1:0] tile_data_t;

    typedef struct packed {
        tile_addr_t addr;
        tile_data_t data;
    } wr_req_t;

    typedef enum logic [1:0] {
        IDLE,
        ARB,
        DATA,
        ACK
    } gl_rd_state_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_VGA,
        GNT_WR,
        GNT_RD
    } grant_t;

endpackage

// File: rtl/arb_wr_fifo.sv
// Game write buffer: FDEPTH-entry FIFO of address/data pairs, synchronous active-high reset.
module arb_wr_fifo
    import tile_arb_pkg::*;
#(
    parameter int unsigned FDEPTH = ARB_FDEPTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  wr_req_t                   push_data,
    input  logic                      pop,
    output wr_req_t                   head,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(FDEPTH):0]   lvl
);

    localparam int unsigned PW = $clog2(FDEPTH);
    localparam int unsigned LW = PW + 1;

    wr_req_t         store [FDEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [LW-1:0]   cnt;
    logic            do_push;
    logic            do_pop;

    // Full is taken from the registered count, so a same-cycle pop never frees a slot.
    assign full    = (cnt == LW'(FDEPTH));
    assign empty   = (cnt == LW'(0));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = store[rd_ptr];
    assign lvl     = cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + LW'(1);
                2'b01:   cnt <= cnt - LW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Payload storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            store[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/tile_mem_arbiter.sv
// Arbitrates the single-port tile RAM between VGA reads, buffered game writes and game reads.
// Define ARB_STAT_EN to build the saturating game-stall counter on stall_cnt.
module tile_mem_arbiter
    import tile_arb_pkg::*;
#(
    parameter int unsigned FDEPTH = ARB_FDEPTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      vga_rd_req,
    input  tile_addr_t                vga_rd_addr,
    output tile_data_t                vga_rd_data,
    output logic                      vga_rd_vld,
    input  logic                      gl_wr_valid,
    output logic                      gl_wr_ready,
    input  tile_addr_t                gl_wr_addr,
    input  tile_data_t                gl_wr_data,
    input  logic                      gl_rd_req,
    input  tile_addr_t                gl_rd_addr,
    output logic                      gl_rd_ack,
    output tile_data_t                gl_rd_data,
    output logic                      mem_en,
    output logic                      mem_we,
    output tile_addr_t                mem_addr,
    output tile_data_t                mem_wdata,
    input  tile_data_t                mem_rdata,
    output logic [$clog2(FDEPTH):0]   fifo_lvl,
    output logic [STAT_W-1:0]         stall_cnt
);

    gl_rd_state_t state;
    grant_t       grant;
    wr_req_t      fifo_head;
    wr_req_t      fifo_in;
    logic         fifo_full;
    logic         fifo_empty;
    logic         fifo_push;
    logic         fifo_pop;
    logic         vga_pend;

    assign fifo_in.addr = gl_wr_addr;
    assign fifo_in.data = gl_wr_data;
    assign gl_wr_ready  = !fifo_full && !reset;
    assign fifo_push    = gl_wr_valid && gl_wr_ready;
    assign fifo_pop     = (grant == GNT_WR);

    arb_wr_fifo #(
        .FDEPTH    (FDEPTH)
    ) u_wr_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (fifo_in),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .lvl       (fifo_lvl)
    );

    // Fixed priority; game reads wait for an empty FIFO so they observe earlier writes.
    always_comb begin
        grant = GNT_NONE;
        if (reset) begin
            grant = GNT_NONE;
        end else if (vga_rd_req) begin
            grant = GNT_VGA;
        end else if (!fifo_empty) begin
            grant = GNT_WR;
        end else if (state == ARB) begin
            grant = GNT_RD;
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (grant)
            GNT_VGA: begin
                mem_en   = 1'b1;
                mem_addr = vga_rd_addr;
            end
            GNT_WR: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = fifo_head.addr;
                mem_wdata = fifo_head.data;
            end
            GNT_RD: begin
                mem_en   = 1'b1;
                mem_addr = gl_rd_addr;
            end
            default: ;
        endcase
    end

    // VGA return pipe and game read FSM; RAM data arrives one cycle after the grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            vga_pend    <= 1'b0;
            vga_rd_vld  <= 1'b0;
            vga_rd_data <= '0;
            gl_rd_ack   <= 1'b0;
            gl_rd_data  <= '0;
        end else begin
            vga_pend   <= (grant == GNT_VGA);
            vga_rd_vld <= vga_pend;
            if (vga_pend) begin
                vga_rd_data <= mem_rdata;
            end
            gl_rd_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (gl_rd_req) begin
                        state <= ARB;
                    end
                end
                ARB: begin
                    if (grant == GNT_RD) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    gl_rd_data <= mem_rdata;
                    gl_rd_ack  <= 1'b1;
                    state      <= ACK;
                end
                ACK: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ARB_STAT_EN
    logic [STAT_W-1:0] stall_q;
    logic              stalled;

    // A cycle counts as stalled when VGA holds the RAM while game traffic is waiting.
    assign stalled = (grant == GNT_VGA) && (!fifo_empty || (state == ARB));

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else if (stalled && (stall_q != {STAT_W{1'b1}})) begin
            stall_q <= stall_q + STAT_W'(1);
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_tile_mem_arbiter.sv
// Directed bench for tile_mem_arbiter with a 1-cycle-latency single-port RAM model.
module tb_tile_mem_arbiter;
    import tile_arb_pkg::*;

    logic                      clk;
    logic                      reset;
    logic                      vga_rd_req;
    tile_addr_t                vga_rd_addr;
    tile_data_t                vga_rd_data;
    logic                      vga_rd_vld;
    logic                      gl_wr_valid;
    logic                      gl_wr_ready;
    tile_addr_t                gl_wr_addr;
    tile_data_t                gl_wr_data;
    logic                      gl_rd_req;
    tile_addr_t                gl_rd_addr;
    logic                      gl_rd_ack;
    tile_data_t                gl_rd_data;
    logic                      mem_en;
    logic                      mem_we;
    tile_addr_t                mem_addr;
    tile_data_t                mem_wdata;
    tile_data_t                mem_rdata;
    logic [$clog2(ARB_FDEPTH):0] fifo_lvl;
    logic [STAT_W-1:0]         stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    bit [7:0]    ram [1024];
    bit [1023:0] wr_done;

`ifdef ARB_STAT_EN
    localparam int unsigned STALL_EXP = 20;
`else
    localparam int unsigned STALL_EXP = 0;
`endif

    tile_mem_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .vga_rd_req  (vga_rd_req),
        .vga_rd_addr (vga_rd_addr),
        .vga_rd_data (vga_rd_data),
        .vga_rd_vld  (vga_rd_vld),
        .gl_wr_valid (gl_wr_valid),
        .gl_wr_ready (gl_wr_ready),
        .gl_wr_addr  (gl_wr_addr),
        .gl_wr_data  (gl_wr_data),
        .gl_rd_req   (gl_rd_req),
        .gl_rd_addr  (gl_rd_addr),
        .gl_rd_ack   (gl_rd_ack),
        .gl_rd_data  (gl_rd_data),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .fifo_lvl    (fifo_lvl),
        .stall_cnt   (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Power-up contents of locations never written by the DUT.
    function automatic logic [7:0] init_val(input int a);
        return 8'((a * 37) ^ 8'h5A);
    endfunction

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr]     <= mem_wdata;
                wr_done[mem_addr] <= 1'b1;
            end else begin
                mem_rdata <= wr_done[mem_addr] ? ram[mem_addr] : init_val(int'(mem_addr));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int lvl_exp [5];
        lvl_exp = '{3, 3, 2, 1, 0};

        reset       = 1'b1;
        vga_rd_req  = 1'b0;
        vga_rd_addr = '0;
        gl_wr_valid = 1'b0;
        gl_wr_addr  = '0;
        gl_wr_data  = '0;
        gl_rd_req   = 1'b0;
        gl_rd_addr  = '0;

        // Reset state
        repeat (3) tick();
        check("rst_vga_vld",  32'(vga_rd_vld),  32'(0));
        check("rst_vga_data", 32'(vga_rd_data), 32'(0));
        check("rst_rd_ack",   32'(gl_rd_ack),   32'(0));
        check("rst_rd_data",  32'(gl_rd_data),  32'(0));
        check("rst_mem_en",   32'(mem_en),      32'(0));
        check("rst_wr_ready", 32'(gl_wr_ready), 32'(0));
        check("rst_lvl",      32'(fifo_lvl),    32'(0));
        check("rst_stall",    32'(stall_cnt),   32'(0));
        reset = 1'b0;
        #1;
        check("wr_ready_after_rst", 32'(gl_wr_ready), 32'(1));
        tick();

        // 1: back-to-back VGA reads, data two cycles after each request
        for (int i = 0; i < 18; i++) begin
            vga_rd_req  = (i < 16);
            vga_rd_addr = tile_addr_t'(i);
            #1;
            if (i < 16) check("t1_mem_addr", 32'(mem_addr), 32'(i));
            tick();
            if (i >= 1 && i <= 16) begin
                check("t1_vld",  32'(vga_rd_vld),  32'(1));
                check("t1_data", 32'(vga_rd_data), 32'(init_val(i - 1)));
            end else begin
                check("t1_vld_idle", 32'(vga_rd_vld), 32'(0));
            end
        end

        // 2: fill FIFO while VGA owns the RAM, then drain in order
        vga_rd_req  = 1'b1;
        vga_rd_addr = '0;
        for (int k = 0; k < 4; k++) begin
            gl_wr_valid = 1'b1;
            gl_wr_addr  = tile_addr_t'(5 + k);
            gl_wr_data  = tile_data_t'(8'hA0 + k);
            #1;
            check("t2_ready", 32'(gl_wr_ready), 32'(1));
            check("t2_no_we", 32'(mem_we),      32'(0));
            tick();
        end
        check("t2_full_lvl",   32'(fifo_lvl),    32'(4));
        check("t2_full_ready", 32'(gl_wr_ready), 32'(0));
        gl_wr_addr = tile_addr_t'(99);
        gl_wr_data = 8'hFF;
        tick();
        check("t2_full_hold_lvl", 32'(fifo_lvl), 32'(4));
        gl_wr_valid = 1'b0;
        vga_rd_req  = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k == 1) begin
                gl_wr_valid = 1'b1;
                gl_wr_addr  = tile_addr_t'(9);
                gl_wr_data  = 8'hA4;
            end else begin
                gl_wr_valid = 1'b0;
            end
            #1;
            check("t2_we",    32'(mem_we),    32'(1));
            check("t2_addr",  32'(mem_addr),  32'(5 + k));
            check("t2_wdata", 32'(mem_wdata), 32'(8'hA0 + k));
            tick();
            check("t2_lvl", 32'(fifo_lvl), 32'(lvl_exp[k]));
        end
        gl_wr_valid = 1'b0;
        check("t2_no_overflow_wr", 32'(wr_done[99]), 32'(0));

        // 3: read-after-write ordering
        gl_wr_valid = 1'b1;
        gl_wr_addr  = tile_addr_t'(10);
        gl_wr_data  = 8'h5C;
        tick();
        gl_wr_valid = 1'b0;
        gl_rd_req   = 1'b1;
        gl_rd_addr  = tile_addr_t'(10);
        n = 0;
        while (!gl_rd_ack && n < 20) begin
            tick();
            n++;
        end
        check("t3_ack",     32'(gl_rd_ack),  32'(1));
        check("t3_latency", 32'(n),          32'(3));
        check("t3_data",    32'(gl_rd_data), 32'(8'h5C));
        gl_rd_req = 1'b0;
        tick();
        check("t3_ack_pulse", 32'(gl_rd_ack), 32'(0));

        // 4: read on an idle bus, ack exactly three cycles later
        gl_rd_req  = 1'b1;
        gl_rd_addr = tile_addr_t'(5);
        #1;
        check("t4_idle_no_en", 32'(mem_en), 32'(0));
        tick();
        check("t4_ack_c1",  32'(gl_rd_ack), 32'(0));
        check("t4_rd_en",   32'(mem_en),    32'(1));
        check("t4_rd_we",   32'(mem_we),    32'(0));
        check("t4_rd_addr", 32'(mem_addr),  32'(5));
        tick();
        check("t4_ack_c2", 32'(gl_rd_ack), 32'(0));
        tick();
        check("t4_ack_c3", 32'(gl_rd_ack),  32'(1));
        check("t4_data",   32'(gl_rd_data), 32'(8'hA0));
        gl_rd_req = 1'b0;
        tick();
        check("t4_ack_pulse", 32'(gl_rd_ack),  32'(0));
        check("t4_data_held", 32'(gl_rd_data), 32'(8'hA0));

        // 5: reset with a read in DATA and writes pending
        gl_rd_req  = 1'b1;
        gl_rd_addr = tile_addr_t'(6);
        tick();
        gl_wr_valid = 1'b1;
        gl_wr_addr  = tile_addr_t'(20);
        gl_wr_data  = 8'h11;
        #1;
        check("t5_rd_grant_addr", 32'(mem_addr), 32'(6));
        check("t5_rd_grant_we",   32'(mem_we),   32'(0));
        tick();
        check("t5_lvl_before", 32'(fifo_lvl), 32'(1));
        reset       = 1'b1;
        gl_wr_addr  = tile_addr_t'(21);
        gl_wr_data  = 8'h22;
        vga_rd_req  = 1'b1;
        #1;
        check("t5_rst_no_en", 32'(mem_en), 32'(0));
        tick();
        check("t5_no_ack", 32'(gl_rd_ack), 32'(0));
        check("t5_lvl",    32'(fifo_lvl),  32'(0));
        reset       = 1'b0;
        gl_wr_valid = 1'b0;
        gl_rd_req   = 1'b0;
        vga_rd_req  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t5_no_late_ack", 32'(gl_rd_ack), 32'(0));
        end
        check("t5_no_wr20", 32'(wr_done[20]), 32'(0));
        check("t5_no_wr21", 32'(wr_done[21]), 32'(0));

        // 5b: in-flight VGA data dropped by reset
        vga_rd_req  = 1'b1;
        vga_rd_addr = tile_addr_t'(3);
        tick();
        vga_rd_req = 1'b0;
        reset      = 1'b1;
        tick();
        check("t5_vga_suppress", 32'(vga_rd_vld), 32'(0));
        reset = 1'b0;
        tick();
        check("t5_vga_quiet", 32'(vga_rd_vld), 32'(0));

        // 6: VGA starves a pending write for 20 cycles
        check("t6_stall_start", 32'(stall_cnt), 32'(0));
        vga_rd_req  = 1'b1;
        vga_rd_addr = '0;
        gl_wr_valid = 1'b1;
        gl_wr_addr  = tile_addr_t'(30);
        gl_wr_data  = 8'h33;
        tick();
        gl_wr_valid = 1'b0;
        check("t6_lvl", 32'(fifo_lvl), 32'(1));
        repeat (20) tick();
        check("t6_stall",       32'(stall_cnt), 32'(STALL_EXP));
        check("t6_still_queued", 32'(fifo_lvl), 32'(1));
        vga_rd_req = 1'b0;
        #1;
        check("t6_drain_we",   32'(mem_we),   32'(1));
        check("t6_drain_addr", 32'(mem_addr), 32'(30));
        tick();
        check("t6_lvl_empty",  32'(fifo_lvl),  32'(0));
        check("t6_stall_hold", 32'(stall_cnt), 32'(STALL_EXP));
        check("t6_ram",        32'(ram[30]),   32'(8'h33));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule
